// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rsa_pkg
// Brief    : Shared defaults, sequencer state encoding and beat type for the
//            RSA input sequencer.
// Revision : 1.0
// ============================================================================
package rsa_pkg;

    localparam int RSA_WIDTH      = 32;
    localparam int RSA_ADDR_WIDTH = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    typedef logic [2*RSA_WIDTH-1:0] rsa_beat_t;

endpackage
`default_nettype wire

// File: rtl/rsa_skid_fifo2.sv
`default_nettype none
// ============================================================================
// Module   : rsa_skid_fifo2
// Brief    : Two-entry valid/ready buffer between the memory return path and
//            the outgoing beat stream.
// Revision : 1.0
// ============================================================================
module rsa_skid_fifo2 #(
    parameter int DW = 65
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic [1:0]    count
);

    logic [DW-1:0] r_mem [2];
    logic          r_wptr;
    logic          r_rptr;
    logic [1:0]    r_count;
    logic          w_push;
    logic          w_pop;

    assign w_pop  = (r_count != 2'd0) && rd_ready;
    // A full buffer can still take a write in the cycle its head drains.
    assign w_push = wr_valid && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= wr_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign rd_valid = (r_count != 2'd0);
    assign rd_data  = r_mem[r_rptr];
    assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/rsa_input_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rsa_input_sequencer
// Brief    : Streams one operand from the dual-port input word memory as
//            2*WIDTH-bit beats. Define RSA_SEQ_REVERSE_EN for MSB-first order.
// Revision : 1.0
// ============================================================================
module rsa_input_sequencer
    import rsa_pkg::*;
#(
    parameter int WIDTH      = RSA_WIDTH,
    parameter int ADDR_WIDTH = RSA_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] num_beats,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] addr1,
    output logic [ADDR_WIDTH-1:0] addr2,
    input  logic [WIDTH-1:0]      dataoutl,
    input  logic [WIDTH-1:0]      dataouth,
    output logic [2*WIDTH-1:0]    out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam logic [ADDR_WIDTH-1:0] c_addr_one = ADDR_WIDTH'(1);

    seq_state_t            r_state;
    seq_state_t            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_num;
    logic [ADDR_WIDTH-1:0] r_issued;
    logic [ADDR_WIDTH-1:0] r_addr1;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic [ADDR_WIDTH-1:0] w_k;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [1:0]            w_count;
    logic [2:0]            w_occ;
    logic                  w_pop;
    logic                  w_issue;
    logic                  w_all_issued;
    logic                  w_last_issue;
    logic                  w_drained;
    logic [2*WIDTH:0]      w_rd_data;

    // Occupancy after this cycle's pop; a slot freed now may be reissued now.
    assign w_pop        = out_valid & out_ready;
    assign w_occ        = {2'b00, r_inflight} + {1'b0, w_count} - {2'b00, w_pop};
    assign w_all_issued = (r_issued == r_num);
    assign w_last_issue = (r_issued == (r_num - c_addr_one));
    assign w_issue      = (r_state == ST_FETCH) && !w_all_issued && (w_occ < 3'd2);
    assign w_drained    = !r_inflight && ((w_count == 2'd0) || ((w_count == 2'd1) && w_pop));

`ifdef RSA_SEQ_REVERSE_EN
    assign w_k = r_num - r_issued - c_addr_one;
`else
    assign w_k = r_issued;
`endif

    assign w_addr_nxt = r_base + (w_k << 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != ST_IDLE);
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (num_beats == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (w_all_issued) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_drained) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base          <= '0;
            r_num           <= '0;
            r_issued        <= '0;
            r_addr1         <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_base   <= base_addr & ~c_addr_one;
                r_num    <= num_beats;
                r_issued <= '0;
            end else if (w_issue) begin
                r_issued <= r_issued + c_addr_one;
                r_addr1  <= w_addr_nxt;
            end
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && w_last_issue;
        end
    end

    rsa_skid_fifo2 #(
        .DW (2*WIDTH + 1)
    ) u_fifo (
        .clk      (clk),
        .rst      (reset),
        .wr_valid (r_inflight),
        .wr_data  ({r_inflight_last, dataouth, dataoutl}),
        .rd_valid (out_valid),
        .rd_ready (out_ready),
        .rd_data  (w_rd_data),
        .count    (w_count)
    );

    assign out_last = w_rd_data[2*WIDTH];
    assign out_data = w_rd_data[2*WIDTH-1:0];
    assign addr1    = r_addr1;
    assign addr2    = {r_addr1[ADDR_WIDTH-1:1], 1'b1};

endmodule
`default_nettype wire
